// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq -- multi-cycle left shifter.
//
// A start in IDLE captures the operand and the shift amount. The operand is
// then shifted left by 2 bits per cycle, or by 1 bit for a single remaining
// step, until the count reaches zero. The result and a sticky overflow flag
// (any 1 pushed out past the MSB) are registered on the way into DONE.
// DONE lasts one cycle and then returns to IDLE.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst    : asynchronous active-high reset
//   start  : begin an operation (only looked at in IDLE)
//   a      : operand, captured when start is accepted
//   shamt  : left-shift amount 0..n-1, captured when start is accepted
//   busy   : high while shifting
//   done   : one-cycle pulse in DONE
//   y      : registered result, held until the next DONE
//   ovf    : registered with y, high if any 1 bit was shifted out of bit n-1
// -----------------------------------------------------------------------------
module shift_seq #(
    parameter int n  = 32,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [n-1:0]  a,
    input  logic [SW-1:0] shamt,
    output logic          busy,
    output logic          done,
    output logic [n-1:0]  y,
    output logic          ovf
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]    state_reg,  state_next;
    logic [n-1:0]  acc_reg,    acc_next;
    logic [SW-1:0] cnt_reg,    cnt_next;
    logic          sticky_reg, sticky_next;
    logic [n-1:0]  y_reg,      y_next;
    logic          ovf_reg,    ovf_next;

    // Fixed-distance shift networks: pure wiring, zero-filled from the bottom.
    logic [n-1:0] acc_sl1;
    logic [n-1:0] acc_sl2;

    genvar gi;
    generate
        for (gi = 0; gi < n; gi++) begin : g_shift
            if (gi >= 2) begin : g_sl2_bit
                assign acc_sl2[gi] = acc_reg[gi-2];
            end else begin : g_sl2_zero
                assign acc_sl2[gi] = 1'b0;
            end
            if (gi >= 1) begin : g_sl1_bit
                assign acc_sl1[gi] = acc_reg[gi-1];
            end else begin : g_sl1_zero
                assign acc_sl1[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        sticky_next = sticky_reg;
        y_next      = y_reg;
        ovf_next    = ovf_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    acc_next    = a;
                    cnt_next    = shamt;
                    sticky_next = 1'b0;
                    state_next  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_reg >= SW'(2)) begin
                    // The two bits about to leave are folded into the sticky flag.
                    acc_next    = acc_sl2;
                    cnt_next    = cnt_reg - SW'(2);
                    sticky_next = sticky_reg | (|acc_reg[n-1:n-2]);
                end else if (cnt_reg == SW'(1)) begin
                    acc_next    = acc_sl1;
                    cnt_next    = '0;
                    sticky_next = sticky_reg | acc_reg[n-1];
                end else begin
                    // Count exhausted: publish the result, even for shamt = 0.
                    y_next     = acc_reg;
                    ovf_next   = sticky_reg;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            sticky_reg <= 1'b0;
            y_reg      <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            sticky_reg <= sticky_next;
            y_reg      <= y_next;
            ovf_reg    <= ovf_next;
        end
    end

    // Status is decoded straight from the state register, so reset clears it
    // immediately and busy/done can never overlap.
    assign busy = (state_reg == ST_SHIFT);
    assign done = (state_reg == ST_DONE);
    assign y    = y_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_shift_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_seq -- self-checking bench for shift_seq (n = 32, SW = 5).
// Expected results come from a plain arithmetic model: a 64-bit shift gives the
// kept low word and the discarded high word, and latency is 1 + ceil(shamt/2).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] y;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_seq #(.n(32), .SW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .ovf   (ovf)
    );

    // Reference model: result, overflow and cycles from acceptance to DONE.
    function automatic void model(input logic [31:0] av, input int s,
                                  output logic [31:0] ey, output logic eovf,
                                  output int elat);
        logic [63:0] full;
        full = {32'd0, av} << s;
        ey   = full[31:0];
        eovf = |full[63:32];
        elat = 1 + (s + 1) / 2;
    endfunction

    // Stimulus driver: called on a falling edge in IDLE. Returns on the falling
    // edge where done is first seen (or after a bounded wait).
    task automatic run_op(input logic [31:0] av, input logic [4:0] sv, input bit hold,
                          output logic [31:0] ry, output logic rovf, output int lat,
                          output int bcnt, output bit overlap, output bit tmo,
                          output bit ymoved);
        logic [31:0] y_before;
        y_before = y;
        start = 1'b1;
        a     = av;
        shamt = sv;
        lat     = 0;
        bcnt    = 0;
        overlap = 1'b0;
        ymoved  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            a = 32'hFFFF_FFFF;
        end else begin
            start = 1'b0;
            a     = $urandom;
            shamt = 5'($urandom);
        end
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            if (y !== y_before) ymoved = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
        tmo  = (done !== 1'b1);
        ry   = y;
        rovf = ovf;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        a     = 32'hDEAD_BEEF;
        shamt = 5'd3;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (y !== 32'd0)   begin errors++; $display("FAIL reset_y got %h want 00000000", y); end
        checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
        $display("reset: busy=%b done=%b y=%h ovf=%b", busy, done, y, ovf);
    endtask

    task automatic test_directed();
        logic [31:0] va [4] = '{32'h0000_0001, 32'h0000_0001, 32'hC000_0001, 32'h1234_5678};
        logic [4:0]  vs [4] = '{5'd2, 5'd31, 5'd3, 5'd0};
        logic [31:0] vy [4] = '{32'h0000_0004, 32'h8000_0000, 32'h0000_0008, 32'h1234_5678};
        logic        vo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int          vl [4] = '{2, 17, 3, 1};
        logic [31:0] ry;
        logic        rovf;
        int          lat, bc;
        bit          ov, tmo, ym;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vs[i], 1'b0, ry, rovf, lat, bc, ov, tmo, ym);
            $display("directed %0d: a=%h shamt=%0d y=%h ovf=%b cycles=%0d busy=%0d",
                     i, va[i], vs[i], ry, rovf, lat, bc);
            checks++; if (tmo) begin errors++; $display("FAIL dir%0d_timeout no done within 40 cycles", i); end
            checks++; if (ry !== vy[i]) begin errors++; $display("FAIL dir%0d_y got %h want %h", i, ry, vy[i]); end
            checks++; if (rovf !== vo[i]) begin errors++; $display("FAIL dir%0d_ovf got %b want %b", i, rovf, vo[i]); end
            checks++; if (lat != vl[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, vl[i]); end
            checks++; if (bc != vl[i]) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, vl[i]); end
            checks++; if (ov) begin errors++; $display("FAIL dir%0d_busy_done_overlap got 1 want 0", i); end
            checks++; if (ym) begin errors++; $display("FAIL dir%0d_y_early got 1 want 0", i); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width got %b want 0", i, done); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ry;
        logic        rovf;
        int          lat, bc;
        bit          ov, tmo, ym;
        // start held high with a = all-ones through SHIFT and DONE
        run_op(32'h0000_0001, 5'd4, 1'b1, ry, rovf, lat, bc, ov, tmo, ym);
        $display("b2b first: y=%h ovf=%b cycles=%0d", ry, rovf, lat);
        checks++; if (tmo) begin errors++; $display("FAIL b2b_timeout no done within 40 cycles"); end
        checks++; if (ry !== 32'h0000_0010) begin errors++; $display("FAIL b2b_y got %h want 00000010", ry); end
        checks++; if (lat != 3) begin errors++; $display("FAIL b2b_latency got %0d want 3", lat); end
        @(negedge clk);
        // first IDLE cycle: the start seen during DONE must not have been taken
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy, done);
        end
        checks++; if (y !== 32'h0000_0010) begin errors++; $display("FAIL b2b_y_hold got %h want 00000010", y); end
        run_op(32'hFFFF_FFFF, 5'd1, 1'b0, ry, rovf, lat, bc, ov, tmo, ym);
        $display("b2b second: y=%h ovf=%b cycles=%0d", ry, rovf, lat);
        checks++; if (ry !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b2_y got %h want fffffffe", ry); end
        checks++; if (rovf !== 1'b1) begin errors++; $display("FAIL b2b2_ovf got %b want 1", rovf); end
        checks++; if (lat != 2) begin errors++; $display("FAIL b2b2_latency got %0d want 2", lat); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [31:0] ry;
        logic        rovf;
        int          lat, bc;
        bit          ov, tmo, ym, seen_done;
        start = 1'b1;
        a     = 32'h0000_000F;
        shamt = 5'd10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %b want 1", busy); end
        // reset mid-cycle, away from any clock edge
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        checks++; if (y !== 32'd0) begin errors++; $display("FAIL abort_y got %h want 00000000", y); end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        checks++; if (seen_done) begin errors++; $display("FAIL abort_no_done got 1 want 0"); end
        run_op(32'h0000_0003, 5'd1, 1'b0, ry, rovf, lat, bc, ov, tmo, ym);
        $display("after abort: y=%h ovf=%b cycles=%0d", ry, rovf, lat);
        checks++; if (ry !== 32'h0000_0006) begin errors++; $display("FAIL abort_next_y got %h want 00000006", ry); end
        checks++; if (lat != 2) begin errors++; $display("FAIL abort_next_latency got %0d want 2", lat); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] av, ry, ey;
        logic [4:0]  sv;
        logic        rovf, eovf;
        int          lat, bc, elat;
        bit          ov, tmo, ym;
        for (int i = 0; i < 40; i++) begin
            av = $urandom;
            sv = 5'($urandom_range(31, 0));
            if (i % 4 == 0) av = av >> sv;   // some operands that fit without overflow
            run_op(av, sv, 1'b0, ry, rovf, lat, bc, ov, tmo, ym);
            model(av, int'(sv), ey, eovf, elat);
            $display("rand %0d: a=%h shamt=%0d y=%h ovf=%b cycles=%0d", i, av, sv, ry, rovf, lat);
            checks++; if (tmo) begin errors++; $display("FAIL rand%0d_timeout no done within 40 cycles", i); end
            checks++; if (ry !== ey) begin errors++; $display("FAIL rand%0d_y got %h want %h", i, ry, ey); end
            checks++; if (rovf !== eovf) begin errors++; $display("FAIL rand%0d_ovf got %b want %b", i, rovf, eovf); end
            checks++; if (lat != elat) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, elat); end
            checks++; if (bc != elat) begin errors++; $display("FAIL rand%0d_busy_cycles got %0d want %0d", i, bc, elat); end
            checks++; if (ov) begin errors++; $display("FAIL rand%0d_busy_done_overlap got 1 want 0", i); end
            checks++; if (ym) begin errors++; $display("FAIL rand%0d_y_early got 1 want 0", i); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL rand%0d_done_width got %b want 0", i, done); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
